// File: rtl/axi_console_pkg.sv
// Shared constants, address decode and status word packing for the console/host MMIO slave.
package axi_console_pkg;

  localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h1000_0000;
  localparam logic [31:0] HOST_ADDR_DEF    = 32'h2000_0000;
  localparam logic [31:0] PASS_MAGIC_DEF   = 32'h075B_CD15;
  localparam logic [31:0] READ_FILLER      = 32'hDEAD_BEEF;

  localparam int unsigned ST_EMPTY_BIT = 0;
  localparam int unsigned ST_FULL_BIT  = 1;
  localparam int unsigned ST_LEVEL_LSB = 8;
  localparam int unsigned ST_LEVEL_W   = 8;

  typedef enum logic [1:0] {
    TGT_CONSOLE,
    TGT_STATUS,
    TGT_HOST,
    TGT_NONE
  } target_e;

  // Word-address decode; byte-offset bits are never passed in.
  function automatic target_e decode(input logic [29:0] word_addr,
                                     input logic [29:0] console_word,
                                     input logic [29:0] host_word);
    if (word_addr == console_word)              return TGT_CONSOLE;
    else if (word_addr == console_word + 30'd1) return TGT_STATUS;
    else if (word_addr == host_word)            return TGT_HOST;
    else                                        return TGT_NONE;
  endfunction

  // Status word layout: level byte, full flag, empty flag.
  function automatic logic [31:0] status_word(input logic [ST_LEVEL_W-1:0] level,
                                              input logic full,
                                              input logic empty);
    logic [31:0] w;
    w = '0;
    w[ST_EMPTY_BIT] = empty;
    w[ST_FULL_BIT]  = full;
    w[ST_LEVEL_LSB +: ST_LEVEL_W] = level;
    return w;
  endfunction

endpackage

// File: rtl/console_tx_fifo.sv
// Byte-wide synchronous FIFO with wrap-bit pointers; push while full is allowed when popping.
module console_tx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level   = wptr - rptr;
  assign head    = mem[rptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer update; wrap bit makes full/empty distinguishable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
    end
  end

  // Storage array, no reset needed: contents are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/axi_console_host.sv
// AXI4-lite MMIO slave: console byte FIFO, sticky host pass/fail word and status register.
module axi_console_host
  import axi_console_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter logic [31:0] PASS_MAGIC   = PASS_MAGIC_DEF,
  parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF,
  parameter logic [31:0] HOST_ADDR    = HOST_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tests_passed,
  output logic        host_written,
  output logic        bus_error
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic          alive;
  logic          aw_lat;
  logic [29:0]   aw_word_q;
  logic          w_lat;
  logic [31:0]   w_data_q;
  logic [3:0]    w_strb_q;
  target_e       wr_tgt;
  target_e       rd_tgt;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic          fifo_pop;
  logic          console_byte;
  logic          wr_stall;
  logic          wr_exec;
  logic          rd_hs;
  logic [31:0]   rd_word;
  logic          unused_lo;

  assign unused_lo = ^{mem_axi_awaddr[1:0], mem_axi_araddr[1:0]};

  assign mem_axi_awready = alive && !aw_lat;
  assign mem_axi_wready  = alive && !w_lat;
  assign mem_axi_arready = alive && !mem_axi_rvalid;

  assign wr_tgt       = decode(aw_word_q, CONSOLE_ADDR[31:2], HOST_ADDR[31:2]);
  assign rd_tgt       = decode(mem_axi_araddr[31:2], CONSOLE_ADDR[31:2], HOST_ADDR[31:2]);
  assign fifo_pop     = tx_valid && tx_ready;
  assign console_byte = (wr_tgt == TGT_CONSOLE) && w_strb_q[0];
  assign wr_stall     = console_byte && fifo_full && !fifo_pop;
  assign wr_exec      = aw_lat && w_lat && !mem_axi_bvalid && !wr_stall;
  assign rd_hs        = mem_axi_arvalid && mem_axi_arready;
  assign tx_valid     = !fifo_empty;

  console_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_exec && console_byte),
    .push_data (w_data_q[7:0]),
    .pop       (fifo_pop),
    .head      (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Write channel: independent AW/W latches, single execution per response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alive          <= 1'b0;
      aw_lat         <= 1'b0;
      aw_word_q      <= '0;
      w_lat          <= 1'b0;
      w_data_q       <= '0;
      w_strb_q       <= '0;
      mem_axi_bvalid <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (mem_axi_awvalid && mem_axi_awready) begin
        aw_lat    <= 1'b1;
        aw_word_q <= mem_axi_awaddr[31:2];
      end else if (wr_exec) begin
        aw_lat <= 1'b0;
      end
      if (mem_axi_wvalid && mem_axi_wready) begin
        w_lat    <= 1'b1;
        w_data_q <= mem_axi_wdata;
        w_strb_q <= mem_axi_wstrb;
      end else if (wr_exec) begin
        w_lat <= 1'b0;
      end
      if (wr_exec)                              mem_axi_bvalid <= 1'b1;
      else if (mem_axi_bvalid && mem_axi_bready) mem_axi_bvalid <= 1'b0;
    end
  end

  // Sticky host and error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tests_passed <= 1'b0;
      host_written <= 1'b0;
      bus_error    <= 1'b0;
    end else begin
      if (wr_exec) begin
        case (wr_tgt)
          TGT_HOST: begin
            host_written <= 1'b1;
            if (w_data_q == PASS_MAGIC && w_strb_q == 4'hF) tests_passed <= 1'b1;
          end
          TGT_STATUS, TGT_NONE: bus_error <= 1'b1;
          default: ;
        endcase
      end
      if (rd_hs && rd_tgt == TGT_NONE) bus_error <= 1'b1;
    end
  end

  // Read data selection for the address presented on AR.
  always_comb begin
    rd_word = READ_FILLER;
    case (rd_tgt)
      TGT_CONSOLE: rd_word = '0;
      TGT_STATUS:  rd_word = status_word(ST_LEVEL_W'(fifo_level), fifo_full, fifo_empty);
      TGT_HOST:    rd_word = {31'b0, tests_passed};
      default:     ;
    endcase
  end

  // Read channel: response registered one cycle after AR, held until rready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_axi_rvalid <= 1'b0;
      mem_axi_rdata  <= '0;
    end else if (rd_hs) begin
      mem_axi_rvalid <= 1'b1;
      mem_axi_rdata  <= rd_word;
    end else if (mem_axi_rvalid && mem_axi_rready) begin
      mem_axi_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_console_host.sv
// Randomized self-checking bench for axi_console_host against a queue-based model.
module tb_axi_console_host;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] CON   = 32'h1000_0000;
  localparam logic [31:0] STA   = 32'h1000_0004;
  localparam logic [31:0] HST   = 32'h2000_0000;
  localparam logic [31:0] MAGIC = 32'h075B_CD15;

  logic        clk;
  logic        reset;
  logic        mem_axi_awvalid, mem_axi_awready;
  logic [31:0] mem_axi_awaddr;
  logic        mem_axi_wvalid, mem_axi_wready;
  logic [31:0] mem_axi_wdata;
  logic [3:0]  mem_axi_wstrb;
  logic        mem_axi_bvalid, mem_axi_bready;
  logic        mem_axi_arvalid, mem_axi_arready;
  logic [31:0] mem_axi_araddr;
  logic        mem_axi_rvalid, mem_axi_rready;
  logic [31:0] mem_axi_rdata;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic        tests_passed, host_written, bus_error;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  bit m_tp, m_hw, m_be;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  axi_console_host #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready), .mem_axi_awaddr(mem_axi_awaddr),
    .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready), .mem_axi_wdata(mem_axi_wdata),
    .mem_axi_wstrb(mem_axi_wstrb), .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
    .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready), .mem_axi_araddr(mem_axi_araddr),
    .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready), .mem_axi_rdata(mem_axi_rdata),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tests_passed(tests_passed), .host_written(host_written), .bus_error(bus_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input int n);
    logic [31:0] w;
    w = '0;
    w[15:8] = 8'(n);
    w[1] = (n == int'(DEPTH));
    w[0] = (n == 0);
    return w;
  endfunction

  // TX sink: every accepted byte must be the oldest one written.
  always @(negedge clk) begin
    if (!reset && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) check("tx_extra", 32'(exp_q.size()), 32'd1);
      else check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic check_flags(input string tag);
    check({tag, "_flags"}, {29'b0, tests_passed, host_written, bus_error}, {29'b0, m_tp, m_hw, m_be});
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    mem_axi_awvalid = 0; mem_axi_wvalid = 0; mem_axi_bready = 0;
    mem_axi_arvalid = 0; mem_axi_rready = 0; tx_ready = 0;
    exp_q.delete();
    m_tp = 0; m_hw = 0; m_be = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Present AW and W with independent start delays; returns after both handshakes.
  task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly);
    bit aw_done, w_done, hs_aw, hs_w;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    mem_axi_awaddr = addr; mem_axi_wdata = data; mem_axi_wstrb = strb;
    while (!(aw_done && w_done) && cyc < 200) begin
      mem_axi_awvalid = !aw_done && (cyc >= aw_dly);
      mem_axi_wvalid  = !w_done && (cyc >= w_dly);
      @(negedge clk);
      hs_aw = mem_axi_awvalid && mem_axi_awready;
      hs_w  = mem_axi_wvalid && mem_axi_wready;
      @(posedge clk); #1;
      aw_done |= hs_aw;
      w_done  |= hs_w;
      cyc++;
    end
    mem_axi_awvalid = 0; mem_axi_wvalid = 0;
    if (!(aw_done && w_done)) check("aw_w_timeout", 32'(cyc), 32'd0);
  endtask

  task automatic wait_b(input int budget, output bit got);
    int cyc;
    cyc = 0; got = 0;
    while (!got && cyc < budget) begin
      @(negedge clk);
      if (mem_axi_bvalid) begin got = 1; mem_axi_bready = 1; end
      @(posedge clk); #1;
      mem_axi_bready = 0;
      cyc++;
    end
    if (got) begin
      @(negedge clk);
      check("bvalid_single", 32'(mem_axi_bvalid), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly);
    bit got;
    send_aw_w(addr, data, strb, aw_dly, w_dly);
    wait_b(50, got);
    check("bresp_seen", 32'(got), 32'd1);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
    bit hs;
    int cyc;
    hs = 0; cyc = 0;
    mem_axi_araddr = addr; mem_axi_arvalid = 1;
    while (!hs && cyc < 50) begin
      @(negedge clk);
      hs = mem_axi_arready;
      @(posedge clk); #1;
      cyc++;
    end
    mem_axi_arvalid = 0;
    if (!hs) check("ar_timeout", 32'(cyc), 32'd0);
    @(negedge clk);
    check("rvalid_latency", 32'(mem_axi_rvalid), 32'd1);
    data = mem_axi_rdata;
    @(posedge clk); #1;
    @(negedge clk);
    check("rdata_stable", mem_axi_rdata, data);
    mem_axi_rready = 1;
    @(posedge clk); #1;
    mem_axi_rready = 0;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    tx_ready = 1;
    while (cyc < 200) begin
      @(negedge clk);
      if (!tx_valid) break;
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    tx_ready = 0;
    check("drain_model_empty", 32'(exp_q.size()), 32'd0);
    check("drain_tx_valid", 32'(tx_valid), 32'd0);
  endtask

  task automatic console_write(input logic [7:0] b);
    exp_q.push_back(b);
    axi_write(CON, {24'h0, b}, 4'hF, 0, 0);
  endtask

  initial begin
    logic [31:0] rd;
    bit got;

    reset = 1; tx_ready = 0;
    mem_axi_awvalid = 0; mem_axi_wvalid = 0; mem_axi_bready = 0;
    mem_axi_arvalid = 0; mem_axi_rready = 0;
    mem_axi_awaddr = 0; mem_axi_wdata = 0; mem_axi_wstrb = 0; mem_axi_araddr = 0;
    #3;
    check("reset_ctrl", {22'b0, mem_axi_awready, mem_axi_wready, mem_axi_arready, mem_axi_bvalid,
                         mem_axi_rvalid, tx_valid, tests_passed, host_written, bus_error, 1'b0}, 32'd0);
    check("reset_rdata", mem_axi_rdata, 32'd0);
    apply_reset();
    @(negedge clk);
    check("ready_after_reset", {29'b0, mem_axi_awready, mem_axi_wready, mem_axi_arready}, 32'd7);
    @(posedge clk); #1;

    // Two console bytes streaming straight out.
    tx_ready = 1;
    console_write(8'h41);
    console_write(8'h42);
    drain();
    axi_read(STA, rd);
    check("status_empty", rd, 32'h0000_0001);

    // Fill, then one write stalls until a single pop.
    for (int i = 0; i < int'(DEPTH); i++) console_write(8'(8'h60 + i));
    axi_read(STA, rd);
    check("status_full", rd, exp_status(DEPTH));
    exp_q.push_back(8'hA5);
    send_aw_w(CON, 32'h0000_00A5, 4'hF, 0, 0);
    wait_b(10, got);
    check("stall_no_b", 32'(got), 32'd0);
    axi_read(STA, rd);
    check("status_full_stalled", rd, exp_status(DEPTH));
    tx_ready = 1;
    @(posedge clk); #1;
    tx_ready = 0;
    wait_b(20, got);
    check("stall_release_b", 32'(got), 32'd1);
    axi_read(STA, rd);
    check("status_refilled", rd, exp_status(DEPTH));
    drain();

    // Host pass with W ahead of AW, then a non-magic write keeps the pass.
    apply_reset();
    axi_write(HST, MAGIC, 4'hF, 3, 0);
    m_tp = 1; m_hw = 1;
    check_flags("host_magic");
    axi_read(HST, rd);
    check("host_read", rd, 32'd1);
    axi_write(HST, 32'd0, 4'hF, 0, 0);
    check_flags("host_sticky");

    // Magic value with partial strobes does not pass.
    apply_reset();
    axi_write(HST | 32'h2, MAGIC, 4'b0011, 0, 1);
    m_hw = 1;
    check_flags("host_partial");

    // Unmapped read and status-register write raise bus_error.
    apply_reset();
    check_flags("be_clear");
    axi_read(32'h3000_0000, rd);
    m_be = 1;
    check("unmapped_read", rd, 32'hDEAD_BEEF);
    check_flags("be_read");
    apply_reset();
    console_write(8'h11);
    console_write(8'h22);
    axi_write(STA, 32'h0000_0033, 4'hF, 1, 0);
    m_be = 1;
    check_flags("be_write");
    axi_read(STA, rd);
    check("status_after_bad_write", rd, exp_status(2));
    drain();

    // Reset with queued bytes, a pending B and a pending R.
    apply_reset();
    for (int i = 0; i < 5; i++) console_write(8'(8'h30 + i));
    exp_q.push_back(8'h35);
    send_aw_w(CON, 32'h35, 4'hF, 0, 0);
    mem_axi_araddr = HST; mem_axi_arvalid = 1;
    @(posedge clk); #1;
    mem_axi_arvalid = 0;
    @(negedge clk);
    check("pre_reset_pending", {29'b0, tx_valid, mem_axi_bvalid, mem_axi_rvalid}, 32'd7);
    #1 reset = 1;
    #1;
    check("async_reset_drop", {29'b0, tx_valid, mem_axi_bvalid, mem_axi_rvalid}, 32'd0);
    apply_reset();
    axi_read(STA, rd);
    check("status_post_reset", rd, 32'h0000_0001);

    // Randomized mix of operations against the model.
    for (int k = 0; k < 60; k++) begin
      int op, ad, wd;
      logic [1:0] lo;
      logic [31:0] d, a;
      logic [3:0] s;
      op = $urandom_range(0, 6);
      lo = 2'($urandom);
      d  = $urandom;
      s  = 4'($urandom);
      ad = $urandom_range(0, 3);
      wd = $urandom_range(0, 3);
      case (op)
        0, 1: begin
          tx_ready = 1'($urandom_range(0, 1));
          if (exp_q.size() >= int'(DEPTH)) tx_ready = 1;
          if (s[0]) exp_q.push_back(d[7:0]);
          axi_write(CON | 32'(lo), d, s, ad, wd);
        end
        2: begin
          if ($urandom_range(0, 1) == 1) d = MAGIC;
          if ($urandom_range(0, 1) == 1) s = 4'hF;
          axi_write(HST | 32'(lo), d, s, ad, wd);
          m_hw = 1;
          if (d == MAGIC && s == 4'hF) m_tp = 1;
        end
        3: begin
          if ($urandom_range(0, 1) == 1) a = STA | 32'(lo);
          else a = {4'($urandom_range(4, 15)), 28'($urandom)};
          axi_write(a, d, s, ad, wd);
          m_be = 1;
        end
        4: begin
          tx_ready = 0;
          @(posedge clk); #1;
          axi_read(STA | 32'(lo), rd);
          check("rand_status", rd, exp_status(exp_q.size()));
        end
        5: begin
          if ($urandom_range(0, 1) == 1) begin
            axi_read(CON | 32'(lo), rd);
            check("rand_console_read", rd, 32'd0);
          end else begin
            axi_read(HST | 32'(lo), rd);
            check("rand_host_read", rd, {31'b0, m_tp});
          end
        end
        default: begin
          axi_read({4'($urandom_range(4, 15)), 28'($urandom)}, rd);
          m_be = 1;
          check("rand_unmapped_read", rd, 32'hDEAD_BEEF);
        end
      endcase
      check_flags("rand");
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_console_host.md
Name: axi_console_host

Overview:
- AXI4-lite slave for the MMIO window of picorv32_axi, next to the main memory slave on the same bus signals.
- The console write register (0x1000_0000) pushes bytes into a TX FIFO. The FIFO drains through a valid/ready byte stream to a UART or bench sink.
- The host word (0x2000_0000) latches pass/fail status. A status register is readable.
- Synthesizable replacement for the behavioural console and pass-flag handling, usable both on FPGA and in simulation.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; power of two, at least 2.
- PASS_MAGIC, 32'h075B_CD15, write value to the host word that sets tests_passed (decimal 123456789).
- CONSOLE_ADDR, 32'h1000_0000, console data register; status register is at CONSOLE_ADDR+4.
- HOST_ADDR, 32'h2000_0000, host word address.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- mem_axi_awvalid  in  1  write address valid
- mem_axi_awready  out  1  write address ready
- mem_axi_awaddr  in  32  write address
- mem_axi_wvalid  in  1  write data valid
- mem_axi_wready  out  1  write data ready
- mem_axi_wdata  in  32  write data
- mem_axi_wstrb  in  4  write strobes
- mem_axi_bvalid  out  1  write response valid
- mem_axi_bready  in  1  write response ready
- mem_axi_arvalid  in  1  read address valid
- mem_axi_arready  out  1  read address ready
- mem_axi_araddr  in  32  read address
- mem_axi_rvalid  out  1  read data valid
- mem_axi_rready  in  1  read data ready
- mem_axi_rdata  out  32  read data
- tx_valid  out  1  console byte available
- tx_ready  in  1  sink accepts byte
- tx_data  out  8  console byte (FIFO head)
- tests_passed  out  1  sticky pass flag
- host_written  out  1  sticky; host word written with any value
- bus_error  out  1  sticky; access to an unmapped address

Behaviour:
- Reset (async assert, sync deassert handled upstream): every output is 0, rdata is 0, FIFO is empty, all latches are cleared.
- AW and W channels are accepted independently. The slave latches one of each: awready=1 while no address is latched, wready=1 while no data is latched. Either may arrive first.
- The write executes in the cycle after both are latched and bvalid=0:
  - Console: if wstrb[0] is set, push wdata[7:0]. If the FIFO is full, execution stalls (bvalid is held off) until space frees.
  - Host: host_written<=1. tests_passed<=1 iff wdata==PASS_MAGIC and wstrb==4'hF. A later non-magic write does not clear tests_passed.
  - Status register (write), or any other address: bus_error<=1, write discarded.
  - In all cases, bvalid<=1 and both latches clear.
- bvalid holds until bready. Latches clear at execution, so a new AW/W may be accepted while bvalid is pending. No second execution may occur while bvalid=1.
- Read path: arready=1 when no read is pending and rvalid=0. rvalid rises 1 cycle after the AR handshake; rdata is stable until rready.
  - Status read returns {16'b0, level[7:0], 6'b0, full, empty}.
  - Console read returns 0.
  - Host read returns {31'b0, tests_passed}.
  - Other addresses return 32'hDEAD_BEEF and set bus_error.
- Address decode compares awaddr/araddr[31:2] only; the low 2 bits are ignored.
- TX stream:
  - tx_valid = !empty; tx_data = head entry. Pop on tx_valid&&tx_ready.
  - Push and pop in the same cycle while full is legal: level is unchanged and no stall occurs.
  - Push while empty: tx_valid rises the next cycle (registered, 1-cycle latency).
- Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. full = (MSBs differ && rest equal); level = wptr-rptr.
- Reset mid-transaction: all pending handshakes are dropped and valids go low asynchronously. The master is reset together with this block.

Decomposition:
- Shared package axi_console_pkg: address constants, PASS_MAGIC, status bit indices, DEADBEEF read filler.
- One sub-module: console_tx_fifo (sync FIFO with push/pop/full/empty/level; parameter DEPTH, width 8).

Test Plan:
- Write 0x41 ('A') then 0x42 to 0x1000_0000 with tx_ready=1 -> tx_data sequence 0x41, 0x42; bvalid once per write; final status read 32'h0000_0001.
- tx_ready=0, 17 console writes at FIFO_DEPTH=16 -> 16 B responses complete. 17th bvalid stays low until one tx_ready pulse, then asserts. Status full bit=1 before the pop.
- W sent 3 cycles before AW to 0x2000_0000, data 0x075B_CD15 -> single bvalid; tests_passed=1, host_written=1. A subsequent write of 0 leaves tests_passed=1.
- Host write 0x075B_CD15 with wstrb=4'b0011 -> host_written=1, tests_passed=0.
- Read 0x3000_0000 -> rdata 32'hDEAD_BEEF, bus_error=1. Write to 0x1000_0004 -> bvalid, bus_error=1, FIFO level unchanged.
- Assert reset with 5 bytes queued and bvalid pending -> tx_valid, bvalid and rvalid drop immediately. After release, status reads 32'h0000_0001.
